// File: rtl/calc_pkg.sv
// Shared types for the serial calculator path: sequencer states, op codes, timeout result.
// Pure declarations; no logic, latency or backpressure of its own.
package calc_pkg;

  typedef enum logic [2:0] {
    LOAD   = 3'd0,
    ARMED  = 3'd1,
    LAUNCH = 3'd2,
    WAIT   = 3'd3,
    OUTPUT = 3'd4
  } calc_state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } calc_op_t;

  // Canonical quiet NaN, reported when the core never answers.
  localparam logic [31:0] CALC_NAN = 32'h7FC0_0000;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for a level input; emits a registered one-cycle pulse.
// Latency: pulse visible one cycle after the input is first sampled high.
// Backpressure: none; edges are never held or queued.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sig_q <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sig_q <= sig;
      rise  <= sig & ~sig_q;
    end
  end

endmodule

// File: rtl/calc_ctrl.sv
// Calculator sequencer: counts operand bytes, launches the core on go, shifts the result out.
// Latency: go edge -> core_start 2 cycles; core_done -> first output_result 1 cycle.
// Backpressure: none; go edges outside ARMED are dropped. CALC_CTRL_TIMEOUT_EN adds a WAIT abort.
module calc_ctrl
  import calc_pkg::*;
#(
  parameter int WORD_BYTES     = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        go,
  input  logic [1:0]  op_in,
  output logic        start_calc,
  output logic        output_result,
  output logic        core_start,
  output logic [1:0]  core_op,
  input  logic        core_done,
  input  logic [31:0] core_result,
  output logic [31:0] z,
  output logic        busy,
  output logic        err
);

  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(2 * WORD_BYTES - 1);
  localparam logic [CNT_W-1:0] OUT_LAST  = CNT_W'(WORD_BYTES - 1);

  calc_state_t      state, state_nxt;
  calc_op_t         op_q;
  logic [CNT_W-1:0] byte_cnt;
  logic             go_rise;
  logic             cnt_inc, cnt_clr, done_take, tmo_hit, tmo_take;

  edge_detect u_go_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (go),
    .rise  (go_rise)
  );

`ifdef CALC_CTRL_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == LAUNCH)
        wait_cnt <= '0;
      else if (state == WAIT)
        wait_cnt <= wait_cnt + CNT_W'(1);
      if (tmo_take)
        err_q <= 1'b1;
    end
  end

  assign tmo_hit = (state == WAIT) && (wait_cnt == TMO_LAST);
  assign err     = err_q;
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= LOAD;
    else
      state <= state_nxt;
  end

  // A core_done coinciding with the timeout takes priority over the abort.
  always_comb begin
    state_nxt = state;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    done_take = 1'b0;
    tmo_take  = 1'b0;
    case (state)
      LOAD: begin
        if (in_valid) begin
          if (byte_cnt == LOAD_LAST) begin
            state_nxt = ARMED;
            cnt_clr   = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      ARMED: begin
        if (go_rise)
          state_nxt = LAUNCH;
      end
      LAUNCH: begin
        state_nxt = WAIT;
        if (core_done) begin
          done_take = 1'b1;
          state_nxt = OUTPUT;
        end
      end
      WAIT: begin
        if (core_done) begin
          done_take = 1'b1;
          state_nxt = OUTPUT;
        end else if (tmo_hit) begin
          tmo_take  = 1'b1;
          state_nxt = OUTPUT;
        end
      end
      OUTPUT: begin
        if (byte_cnt == OUT_LAST) begin
          state_nxt = LOAD;
          cnt_clr   = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  // op is captured on entry to LAUNCH so it is already valid alongside core_start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_cnt <= '0;
      op_q     <= OP_ADD;
      z        <= '0;
    end else begin
      if (cnt_clr)
        byte_cnt <= '0;
      else if (cnt_inc)
        byte_cnt <= byte_cnt + CNT_W'(1);
      if (state == ARMED && go_rise)
        op_q <= calc_op_t'(op_in);
      if (done_take)
        z <= core_result;
      else if (tmo_take)
        z <= CALC_NAN;
    end
  end

  assign start_calc    = (state != LOAD);
  assign busy          = (state != LOAD);
  assign output_result = (state == OUTPUT);
  assign core_start    = (state == LAUNCH);
  assign core_op       = op_q;

endmodule
